// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the pipeline-stage registers.
//   RV32I_NOP       : canonical NOP encoding (addi x0,x0,0), used as the
//                     bubble value whenever a stage holds nothing valid.
//   stage_state_e   : occupancy state of an elastic stage register. The
//                     encoding equals the number of held entries, so it can
//                     be exported directly as an occupancy count.
// ---------------------------------------------------------------------------
package riscv_pkg;

    localparam logic [31:0] RV32I_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } stage_state_e;

endpackage : riscv_pkg

// File: rtl/pipe_skid_stage.sv
// ---------------------------------------------------------------------------
// pipe_skid_stage
// Two-entry elastic pipeline register (main + skid) between two pipeline
// stages. Forward (valid/data) and backward (ready) paths are both fully
// registered. When nothing valid is held, out_data shows BUBBLE_VALUE.
//
// Ports
//   clk        : rising-edge clock
//   rst_n      : synchronous active-low reset (priority over flush)
//   flush      : synchronous flush, discards all held entries
//   in_valid   : upstream offers in_data
//   in_ready   : stage accepts in_data this cycle (registered)
//   in_data    : upstream payload
//   out_valid  : out_data holds a valid entry (registered)
//   out_ready  : downstream accepts out_data this cycle
//   out_data   : oldest held entry, or BUBBLE_VALUE (registered)
//   count      : number of held entries; equal to the FSM state encoding,
//                so it doubles as the state debug output
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. A producer holding valid=1 keeps its data stable until the
// transfer; ready never depends combinationally on valid in this block.
// ---------------------------------------------------------------------------
module pipe_skid_stage
    import riscv_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] BUBBLE_VALUE = WIDTH'(RV32I_NOP)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    stage_state_e     state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_ready_q;
    logic             out_valid_q;

    logic in_xfer;
    logic out_xfer;

    assign in_xfer  = in_valid & in_ready_q;
    assign out_xfer = out_valid_q & out_ready;

    // Next-state and datapath steering.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        unique case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    main_d  = in_data;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    main_d = in_data;
                end else if (in_xfer) begin
                    // Downstream stalled while an entry was in flight:
                    // the skid register absorbs it.
                    skid_d  = in_data;
                    state_d = FULL;
                end else if (out_xfer) begin
                    main_d  = BUBBLE_VALUE;
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // in_ready is low here, so only the drain path exists.
                if (out_xfer) begin
                    main_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: begin
                main_d  = BUBBLE_VALUE;
                state_d = EMPTY;
            end
        endcase

        // Flush wins over any same-cycle acceptance; an out_xfer in this
        // cycle has already been sampled by downstream from main_q.
        if (flush) begin
            main_d  = BUBBLE_VALUE;
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            main_q      <= BUBBLE_VALUE;
            skid_q      <= BUBBLE_VALUE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            // Registered copies of decoded state so every output is a flop.
            in_ready_q  <= (state_d != FULL);
            out_valid_q <= (state_d != EMPTY);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;
    assign count     = state_q;

endmodule : pipe_skid_stage

// File: tb/tb_pipe_skid_stage.sv
module tb_pipe_skid_stage;

    localparam int          W   = 32;
    localparam logic [31:0] NOP = 32'h0000_0013;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   count;

    always #5 clk = ~clk;

    pipe_skid_stage #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .count    (count)
    );

    int total = 0;
    int bad   = 0;

    logic [W-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one clock edge; outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [W-1:0] d, input logic ordy, input logic fl);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
    endtask

    // One scoreboarded cycle: inputs applied, transfers predicted from the
    // pre-edge signals, then the edge and the post-edge checks.
    logic [W-1:0] seq = 32'h1000;

    task automatic sb_cycle(input logic iv, input logic ordy, input logic fl);
        logic         in_x, out_x, hold;
        logic [W-1:0] d, prev_data;
        d = iv ? seq : W'($urandom);
        drive(iv, d, ordy, fl);
        #1;
        in_x      = in_valid & in_ready;
        out_x     = out_valid & out_ready;
        hold      = out_valid & ~out_ready & ~fl;
        prev_data = out_data;
        if (out_x) begin
            if (exp_q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
            else chk("sb_order", out_data, exp_q.pop_front());
        end
        if (fl) exp_q.delete();
        else if (in_x) begin
            exp_q.push_back(d);
            seq++;
        end
        tick();
        chk("sb_count", W'(count), W'(exp_q.size()));
        chk("sb_le2", W'(count <= 2'd2), 32'd1);
        chk("sb_valid", W'(out_valid), W'(exp_q.size() != 0));
        chk("sb_ready", W'(in_ready), W'(exp_q.size() != 2));
        if (exp_q.size() == 0) chk("sb_bubble", out_data, NOP);
        if (hold) begin
            chk("sb_stable_d", out_data, prev_data);
            chk("sb_stable_v", W'(out_valid), 32'd1);
        end
    endtask

    initial begin
        // ---------------- reset ----------------
        rst_n = 1'b0;
        drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        drive(1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0);
        chk("rst_valid", W'(out_valid), 32'd0);
        chk("rst_data", out_data, NOP);
        chk("rst_ready", W'(in_ready), 32'd1);
        chk("rst_count", W'(count), 32'd0);

        // ---------------- streaming ----------------
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, W'(i), 1'b1, 1'b0);
            tick();
            chk("stream_data", out_data, W'(i));
            chk("stream_valid", W'(out_valid), 32'd1);
            chk("stream_count", W'(count), 32'd1);
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        chk("stream_drain", W'(count), 32'd0);
        chk("stream_bubble", out_data, NOP);

        // ---------------- backpressure ----------------
        drive(1'b1, 32'd10, 1'b1, 1'b0);
        tick();
        chk("bp_first", out_data, 32'd10);
        drive(1'b1, 32'd11, 1'b0, 1'b0);
        tick();
        chk("bp_full_cnt", W'(count), 32'd2);
        chk("bp_full_rdy", W'(in_ready), 32'd0);
        chk("bp_full_data", out_data, 32'd10);
        drive(1'b1, 32'd12, 1'b0, 1'b0);
        tick();
        chk("bp_hold_cnt", W'(count), 32'd2);
        chk("bp_hold_data", out_data, 32'd10);
        chk("bp_hold_rdy", W'(in_ready), 32'd0);
        drive(1'b1, 32'd12, 1'b1, 1'b0);
        tick();
        chk("bp_drain11", out_data, 32'd11);
        chk("bp_drain_cnt", W'(count), 32'd1);
        chk("bp_drain_rdy", W'(in_ready), 32'd1);
        tick();
        chk("bp_drain12", out_data, 32'd12);
        chk("bp_drain12_cnt", W'(count), 32'd1);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        chk("bp_empty", W'(count), 32'd0);

        // ---------------- flush while full ----------------
        drive(1'b1, 32'd20, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'd21, 1'b0, 1'b0);
        tick();
        chk("fl_pre_cnt", W'(count), 32'd2);
        chk("fl_pre_data", out_data, 32'd20);
        drive(1'b1, 32'd22, 1'b0, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        chk("fl_valid", W'(out_valid), 32'd0);
        chk("fl_data", out_data, NOP);
        chk("fl_count", W'(count), 32'd0);
        chk("fl_ready", W'(in_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("fl_no22", W'(out_valid), 32'd0);
        end

        // ---------------- flush beats a same-cycle accept ----------------
        drive(1'b1, 32'd30, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'd31, 1'b0, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("fl1_count", W'(count), 32'd0);
        chk("fl1_data", out_data, NOP);
        tick();
        chk("fl1_no31", W'(out_valid), 32'd0);

        // ---------------- bubble hygiene ----------------
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, W'($urandom), 1'(($urandom_range(0, 1))), 1'b0);
            tick();
            chk("bub_data", out_data, NOP);
            chk("bub_valid", W'(out_valid), 32'd0);
        end

        // ---------------- randomized against scoreboard ----------------
        exp_q.delete();
        for (int i = 0; i < 10000; i++) begin
            sb_cycle(1'($urandom_range(0, 99) < 70),
                     1'($urandom_range(0, 99) < 60),
                     1'($urandom_range(0, 199) == 0));
        end
        for (int i = 0; i < 4; i++) sb_cycle(1'b0, 1'b1, 1'b0);
        chk("sb_all_drained", W'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pipe_skid_stage
